data_mem_responder: RTL

- Parametrised data-memory slave that answers the core's load/store port (mem_rd / mem_wr_valid / data_ready).
- Replaces the fixed single-cycle memory model with a configurable-depth word array, programmable wait states, byte-enabled stores, and an error response for bad addresses.
- Sits between the core's data port and the bench, or the on-chip SRAM wrapper in IoT builds.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 109 ++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Core data-port bundle: load/store request from the core, one-cycle response back.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_rd;
    logic                    mem_wr_valid;
    logic [ADDR_WIDTH-1:0]   data_mem_addr;
    logic [DATA_WIDTH-1:0]   to_data_mem;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [DATA_WIDTH-1:0]   from_data_mem;
    logic                    data_ready;
    logic                    mem_err;

    modport master (
        output mem_rd, mem_wr_valid, data_mem_addr, to_data_mem, byte_en,
        input  from_data_mem, data_ready, mem_err
    );

    modport slave (
        input  mem_rd, mem_wr_valid, data_mem_addr, to_data_mem, byte_en,
        output from_data_mem, data_ready, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory slave: word array with programmable wait states, byte-enabled
// stores and an error response for misaligned / out-of-range / conflicting requests.
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NB-1:0]         be_q, be_d;
    logic                  rd_q, rd_d, wr_q, wr_d, err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic req, addr_bad, enter_resp, we;

    assign req        = bus.mem_rd | bus.mem_wr_valid;
    assign addr_bad   = (|bus.data_mem_addr[1:0]) |
                        (|bus.data_mem_addr[ADDR_WIDTH-1:IDX_W+2]);
    assign enter_resp = (state_q == WAIT) && (cnt_q == CNT_W'(1));
    assign we         = enter_resp && wr_q && !err_q;

    // The capture cycle is always spent in WAIT, so the counter is loaded with
    // LATENCY+1 and RESP is entered LATENCY+1 edges after the request is sampled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY + 1);
                    idx_d   = bus.data_mem_addr[IDX_W+1:2];
                    wdata_d = bus.to_data_mem;
                    be_d    = bus.byte_en;
                    rd_d    = bus.mem_rd;
                    wr_d    = bus.mem_wr_valid;
                    err_d   = addr_bad | (bus.mem_rd & bus.mem_wr_valid);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (enter_resp) begin
                    state_d = RESP;
                    if (err_q)     rdata_d = '0;
                    else if (rd_q) rdata_d = mem[idx_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array contents survive reset; a reset mid-access leaves state_q in IDLE so no write fires.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we && be_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
    end

    assign bus.data_ready    = (state_q == RESP);
    assign bus.mem_err       = (state_q == RESP) & err_q;
    assign bus.from_data_mem = rdata_q;
endmodule
